// File: rtl/div_16_pkg.sv
// Shared types and constants for the 16-bit iterative restoring divider.
package div_16_pkg;

   localparam int unsigned DIV_WIDTH = 16;
   localparam int unsigned CNT_W     = 5;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div_16_if.sv
// Start/done request bus between a requester and the divider.
interface div_16_if;
   import div_16_pkg::*;

   logic                 start;
   logic [DIV_WIDTH-1:0] dividend;
   logic [DIV_WIDTH-1:0] divisor;
   logic                 ready;
   logic                 done;
   logic [DIV_WIDTH-1:0] quotient;
   logic [DIV_WIDTH-1:0] remainder;
   logic                 div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/fa.sv
// One-bit full-adder cell shared with the ALU adder path.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum_c,
   output logic cout_c
);

   assign sum_c  = a ^ b ^ ci;
   assign cout_c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sub_17.sv
// Ripple subtractor a - b built from fa cells: b inverted, carry-in tied high.
module sub_17 #(
   parameter int unsigned W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff_c,
   output logic         no_borrow_c
);

   logic [W:0] carry;

   assign carry[0]    = 1'b1;
   assign no_borrow_c = carry[W];

   for (genvar i = 0; i < W; i++) begin : g_bit
      fa u_fa (
         .a      (a[i]),
         .b      (~b[i]),
         .ci     (carry[i]),
         .sum_c  (diff_c[i]),
         .cout_c (carry[i+1])
      );
   end

endmodule

// File: rtl/div_16.sv
// Unsigned restoring divider: one quotient bit per clock, start/done handshake.
module div_16
   import div_16_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic     clock,
   input  logic     reset,
   div_16_if.slave  bus
);

   localparam int unsigned RW = WIDTH + 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [RW-1:0]      r_q, r_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dbz_q, dbz_d;

   logic [RW-1:0]      s_c;
   logic [RW-1:0]      t_c;
   logic [RW-1:0]      r_next_c;
   logic [WIDTH-1:0]   q_next_c;
   logic               no_borrow_c;
   logic               unused_c;

   // Shift in the next dividend bit and trial-subtract the divisor.
   assign s_c = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

   sub_17 #(.W(RW)) u_sub (
      .a           (s_c),
      .b           ({1'b0, d_q}),
      .diff_c      (t_c),
      .no_borrow_c (no_borrow_c)
   );

   assign r_next_c = no_borrow_c ? t_c : s_c;
   assign q_next_c = {q_q[WIDTH-2:0], no_borrow_c};
   // R stays below D after every step, so its top bit is never needed as input.
   assign unused_c = r_q[WIDTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               q_d     = bus.dividend;
               d_d     = bus.divisor;
               r_d     = '0;
               cnt_d   = '0;
               dbz_d   = 1'b0;
               zero_d  = (bus.divisor == '0);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // A zero divisor spends a single cycle here without iterating.
            if (zero_q) begin
               quot_d  = WIDTH'(DIV_ZERO_Q);
               rem_d   = q_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               q_d   = q_next_c;
               r_d   = r_next_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  quot_d  = q_next_c;
                  rem_d   = r_next_c[WIDTH-1:0];
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.ready       = (state_q == S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16.sv
// Self-checking bench for div_16: directed corner cases plus a randomized back-to-back stream.
module tb_div_16;
   import div_16_pkg::*;

   localparam int unsigned N_RAND  = 500;
   localparam int          MAX_LAT = 40;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   div_16_if bus();

   div_16 dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t ref_div(input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      int unsigned ua = a;
      int unsigned ub = b;
      if (ub == 0) begin
         e.q = 16'hFFFF;
         e.r = a;
         e.z = 1'b1;
      end else begin
         e.q = 16'(ua / ub);
         e.r = 16'(ua % ub);
         e.z = 1'b0;
      end
      return e;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the divider idle; returns at the negedge where done is seen.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic rdy_seen);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      lat       = 1;
      rdy_seen  = bus.ready;
      while (!bus.done && lat < MAX_LAT) begin
         @(negedge clock);
         lat++;
         rdy_seen = rdy_seen | bus.ready;
      end
   endtask

   task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] eq, input logic [15:0] er, input logic ez,
                            input int elat);
      int   lat;
      logic rdy_seen;
      do_op(a, b, lat, rdy_seen);
      check_val({tag, "_lat"}, 32'(lat), 32'(elat));
      check_val({tag, "_q"}, 32'(bus.quotient), 32'(eq));
      check_val({tag, "_r"}, 32'(bus.remainder), 32'(er));
      check_val({tag, "_z"}, 32'(bus.div_by_zero), 32'(ez));
      check_val({tag, "_busy_rdy"}, 32'(rdy_seen), 32'(0));
      @(negedge clock);
      check_val({tag, "_idle_rdy"}, 32'(bus.ready), 32'(1));
   endtask

   task automatic issue_next();
      logic [15:0] a;
      logic [15:0] b;
      int          mode;
      mode = $urandom_range(0, 9);
      a    = 16'($urandom);
      case (mode)
         0: b = 16'd1;
         1: begin
            b = 16'($urandom_range(1, 65535));
            a = 16'($urandom % b);
         end
         2: b = 16'd0;
         3: b = 16'($urandom_range(1, 255));
         default: b = 16'($urandom);
      endcase
      bus.dividend = a;
      bus.divisor  = b;
      exp_q.push_back(ref_div(a, b));
   endtask

   initial begin
      int   lat;
      logic rdy_seen;
      logic dn;
      int   issued;
      int   got;
      int   cyc;
      int   stray;
      exp_t e;

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_val("rst_ready", 32'(bus.ready), 32'(1));
      check_val("rst_done", 32'(bus.done), 32'(0));
      check_val("rst_q", 32'(bus.quotient), 32'(0));
      check_val("rst_r", 32'(bus.remainder), 32'(0));
      check_val("rst_z", 32'(bus.div_by_zero), 32'(0));

      run_check("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      run_check("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
      run_check("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
      run_check("d8000_ffff", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 17);
      run_check("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 2);
      run_check("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

      // A start pulse during RUN must be ignored.
      bus.dividend = 16'd1000;
      bus.divisor  = 16'd9;
      bus.start    = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      lat       = 1;
      rdy_seen  = bus.ready;
      while (!bus.done && lat < MAX_LAT) begin
         if (lat == 5) begin
            bus.start    = 1'b1;
            bus.dividend = 16'd50;
            bus.divisor  = 16'd5;
         end
         @(negedge clock);
         bus.start = 1'b0;
         lat++;
         rdy_seen = rdy_seen | bus.ready;
      end
      check_val("ign_lat", 32'(lat), 32'(17));
      check_val("ign_q", 32'(bus.quotient), 32'(111));
      check_val("ign_r", 32'(bus.remainder), 32'(1));
      check_val("ign_busy_rdy", 32'(rdy_seen), 32'(0));
      @(negedge clock);
      check_val("ign_idle_rdy", 32'(bus.ready), 32'(1));
      check_val("ign_done_once", 32'(bus.done), 32'(0));

      // Reset in the eighth RUN cycle discards the operation.
      bus.dividend = 16'd1000;
      bus.divisor  = 16'd9;
      bus.start    = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      dn        = bus.done;
      repeat (7) begin
         @(negedge clock);
         dn = dn | bus.done;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      dn    = dn | bus.done;
      check_val("mrst_no_done", 32'(dn), 32'(0));
      check_val("mrst_ready", 32'(bus.ready), 32'(1));
      check_val("mrst_q", 32'(bus.quotient), 32'(0));
      check_val("mrst_r", 32'(bus.remainder), 32'(0));
      check_val("mrst_z", 32'(bus.div_by_zero), 32'(0));
      run_check("d20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 17);

      // Back-to-back stream with start held high.
      issue_next();
      issued    = 1;
      got       = 0;
      cyc       = 0;
      bus.start = 1'b1;
      while (got < int'(N_RAND) && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         if (bus.done) begin
            check_val("rnd_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_val("rnd_q", 32'(bus.quotient), 32'(e.q));
               check_val("rnd_r", 32'(bus.remainder), 32'(e.r));
               check_val("rnd_z", 32'(bus.div_by_zero), 32'(e.z));
            end
            got++;
         end
         if (bus.ready) begin
            if (issued < int'(N_RAND)) begin
               issue_next();
               issued++;
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check_val("rnd_done_count", 32'(got), 32'(N_RAND));
      check_val("rnd_queue_empty", 32'(exp_q.size()), 32'(0));

      stray = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.done) stray++;
      end
      check_val("rnd_stray_done", 32'(stray), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
